// File: rtl/convertidor_inverso_pkg.sv
// Shared constants and state encoding for the inverse 5/2 converter.
// The divider works on N = 2*x + 4, so the quotient is ceil(2*x/5).
package convertidor_inverso_pkg;

  localparam int ANCHO_ENTRADA_DEF = 10;
  localparam int ANCHO_SALIDA_DEF  = 8;
  localparam int ANCHO_NUM         = ANCHO_ENTRADA_DEF + 2;

  localparam logic [2:0] DIVISOR = 3'd5;
  // Adding 4 before dividing by 5 turns the floor quotient into a ceiling.
  localparam logic [2:0] SESGO   = 3'd4;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    DIVIDIR = 2'd1,
    LISTO   = 2'd2
  } estado_t;

endpackage

// File: rtl/convertidor_inverso_divisor_serie_5.sv
// Restoring shift-subtract divider by 5, one quotient bit per cycle, MSB first.
// o_cociente/o_resto show the values that the current step will register.
module divisor_serie_5
  import convertidor_inverso_pkg::*;
#(
  parameter int ANCHO_N = ANCHO_NUM
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_inicio,
  input  logic               i_paso,
  input  logic [ANCHO_N-1:0] i_num,
  output logic               o_ultimo,
  output logic [ANCHO_N-1:0] o_cociente,
  output logic [2:0]         o_resto
);

  localparam int ANCHO_CUENTA = $clog2(ANCHO_N + 1);

  logic [ANCHO_N-1:0]      r_num;
  logic [ANCHO_N-1:0]      r_cociente;
  logic [2:0]              r_resto;
  logic [ANCHO_CUENTA-1:0] r_cuenta;

  logic [3:0] w_prueba;
  logic [3:0] w_dif;
  logic       w_resta;

  // Trial remainder never exceeds 9, so four bits suffice and the
  // restored remainder always fits back into three.
  assign w_prueba   = {r_resto, r_num[ANCHO_N-1]};
  assign w_resta    = (w_prueba >= {1'b0, DIVISOR});
  assign w_dif      = w_prueba - {1'b0, DIVISOR};
  assign o_resto    = w_resta ? w_dif[2:0] : w_prueba[2:0];
  assign o_cociente = {r_cociente[ANCHO_N-2:0], w_resta};
  assign o_ultimo   = (r_cuenta == ANCHO_CUENTA'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num      <= '0;
      r_cociente <= '0;
      r_resto    <= '0;
      r_cuenta   <= '0;
    end else if (i_inicio) begin
      r_num      <= i_num;
      r_cociente <= '0;
      r_resto    <= '0;
      r_cuenta   <= ANCHO_CUENTA'(ANCHO_N);
    end else if (i_paso && (r_cuenta != '0)) begin
      r_num      <= {r_num[ANCHO_N-2:0], 1'b0};
      r_cociente <= o_cociente;
      r_resto    <= o_resto;
      r_cuenta   <= r_cuenta - ANCHO_CUENTA'(1);
    end
  end

endmodule

// File: rtl/convertidor_inverso.sv
// Converts a 10-bit scaled value back to 8 bits: ceil(2*x/5), saturated.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module convertidor_inverso
  import convertidor_inverso_pkg::*;
#(
  parameter int ANCHO_ENTRADA = ANCHO_ENTRADA_DEF,
  parameter int ANCHO_SALIDA  = ANCHO_SALIDA_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     entrada_valida,
  output logic                     entrada_lista,
  input  logic [ANCHO_ENTRADA-1:0] datoEntrada,
  output logic                     salida_valida,
  input  logic                     salida_lista,
  output logic [ANCHO_SALIDA-1:0]  datoSalida,
  output logic                     saturado,
  output logic                     en_imagen,
  output logic [1:0]               o_estado
);

  localparam int                 ANCHO_N = ANCHO_ENTRADA + 2;
  localparam logic [ANCHO_N-1:0] MAX_SAL = ANCHO_N'((1 << ANCHO_SALIDA) - 1);

  estado_t r_estado;
  estado_t w_estado_sig;

  logic [ANCHO_SALIDA-1:0] r_dato;
  logic                    r_saturado;
  logic                    r_en_imagen;

  logic               w_inicio;
  logic               w_paso;
  logic               w_cargar;
  logic               w_ultimo;
  logic [ANCHO_N-1:0] w_num;
  logic [ANCHO_N-1:0] w_cociente_sig;
  logic [2:0]         w_resto_sig;
  logic               w_sat;

  assign w_num = {1'b0, datoEntrada, 1'b0} + {{(ANCHO_N-3){1'b0}}, SESGO};

  divisor_serie_5 #(.ANCHO_N(ANCHO_N)) u_divisor (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inicio   (w_inicio),
    .i_paso     (w_paso),
    .i_num      (w_num),
    .o_ultimo   (w_ultimo),
    .o_cociente (w_cociente_sig),
    .o_resto    (w_resto_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= REPOSO;
    else        r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    w_inicio     = 1'b0;
    w_paso       = 1'b0;
    w_cargar     = 1'b0;
    unique case (r_estado)
      REPOSO: begin
        if (entrada_valida) begin
          w_inicio     = 1'b1;
          w_estado_sig = DIVIDIR;
        end
      end
      DIVIDIR: begin
        w_paso = 1'b1;
        if (w_ultimo) begin
          w_cargar     = 1'b1;
          w_estado_sig = LISTO;
        end
      end
      LISTO: begin
        if (salida_lista) w_estado_sig = REPOSO;
      end
      default: w_estado_sig = REPOSO;
    endcase
  end

  // Remainder 3 or 4 of (2x+4)/5 is exactly what floor(5q/2) leaves behind.
  assign w_sat = (w_cociente_sig > MAX_SAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dato      <= '0;
      r_saturado  <= 1'b0;
      r_en_imagen <= 1'b0;
    end else if (w_cargar) begin
      r_dato      <= w_sat ? '1 : w_cociente_sig[ANCHO_SALIDA-1:0];
      r_saturado  <= w_sat;
      r_en_imagen <= (w_resto_sig >= 3'd3) && !w_sat;
    end
  end

  assign entrada_lista = (r_estado == REPOSO);
  assign salida_valida = (r_estado == LISTO);
  assign datoSalida    = r_dato;
  assign saturado      = r_saturado;
  assign en_imagen     = r_en_imagen;
  assign o_estado      = r_estado;

endmodule

// File: tb/tb_convertidor_inverso.sv
// Self-checking bench for convertidor_inverso against a behavioural model.
module tb_convertidor_inverso;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entrada_valida = 1'b0;
  logic       salida_lista = 1'b0;
  logic [9:0] datoEntrada = '0;
  logic       entrada_lista;
  logic       salida_valida;
  logic [7:0] datoSalida;
  logic       saturado;
  logic       en_imagen;
  logic [1:0] o_estado;

  int checks = 0;
  int failures = 0;
  // Expected result packed as {en_imagen, saturado, datoSalida}.
  logic [9:0] exp_q[$];

  convertidor_inverso dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .entrada_valida (entrada_valida),
    .entrada_lista  (entrada_lista),
    .datoEntrada    (datoEntrada),
    .salida_valida  (salida_valida),
    .salida_lista   (salida_lista),
    .datoSalida     (datoSalida),
    .saturado       (saturado),
    .en_imagen      (en_imagen),
    .o_estado       (o_estado)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: ceiling of 2d/5, clamp to 255, and a brute-force search of the
  // forward scaler's image.
  function automatic logic [9:0] modelo(input int d);
    int q;
    logic sat, img;
    logic [7:0] dato;
    q = (2 * d + 4) / 5;
    sat = (q > 255);
    dato = sat ? 8'd255 : q[7:0];
    img = 1'b0;
    for (int x = 0; x <= 255; x++)
      if ((5 * x) / 2 == d) img = 1'b1;
    return {img, sat, dato};
  endfunction

  always @(negedge clk)
    if (rst_n) chk("exclusion", {31'd0, entrada_lista & salida_valida}, 32'd0);

  // Driver: one full transaction, with 'espera' cycles of back-pressure.
  task automatic convertir(input logic [9:0] d, input int espera);
    int lat;
    logic [9:0] e;
    @(negedge clk);
    chk("entrada_lista", {31'd0, entrada_lista}, 32'd1);
    datoEntrada = d;
    entrada_valida = 1'b1;
    exp_q.push_back(modelo(int'(d)));
    @(posedge clk);
    #1;
    entrada_valida = 1'b0;
    datoEntrada = 10'($urandom_range(0, 1023));
    lat = 0;
    while (!salida_valida && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latencia", lat, 12);
    e = exp_q.pop_front();
    chk("datoSalida", {24'd0, datoSalida}, {24'd0, e[7:0]});
    chk("saturado", {31'd0, saturado}, {31'd0, e[8]});
    chk("en_imagen", {31'd0, en_imagen}, {31'd0, e[9]});
    repeat (espera) begin
      @(negedge clk);
      chk("retenido", {23'd0, salida_valida, datoSalida}, {23'd1, e[7:0]});
    end
    @(negedge clk);
    salida_lista = 1'b1;
    @(posedge clk);
    #1;
    salida_lista = 1'b0;
    chk("handshake", {31'd0, salida_valida}, 32'd0);
  endtask

  task automatic fijo(input logic [9:0] d, input logic [7:0] dato, input logic sat, input logic img);
    convertir(d, 0);
    chk("tabla_dato", {24'd0, datoSalida}, {24'd0, dato});
    chk("tabla_sat", {31'd0, saturado}, {31'd0, sat});
    chk("tabla_img", {31'd0, en_imagen}, {31'd0, img});
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_entrada_lista", {31'd0, entrada_lista}, 32'd1);
    chk("rst_salida_valida", {31'd0, salida_valida}, 32'd0);
    chk("rst_dato", {24'd0, datoSalida}, 32'd0);
    chk("rst_flags", {30'd0, saturado, en_imagen}, 32'd0);
    rst_n = 1'b1;

    fijo(10'd5,    8'd2,   1'b0, 1'b1);
    fijo(10'd637,  8'd255, 1'b0, 1'b1);
    fijo(10'd0,    8'd0,   1'b0, 1'b1);
    fijo(10'd638,  8'd255, 1'b1, 1'b0);
    fijo(10'd1023, 8'd255, 1'b1, 1'b0);
    fijo(10'd3,    8'd2,   1'b0, 1'b0);

    for (int x = 0; x <= 255; x++) begin
      convertir(10'((5 * x) / 2), 0);
      chk("barrido_dato", {24'd0, datoSalida}, x);
      chk("barrido_img", {31'd0, en_imagen}, 32'd1);
    end

    for (int i = 0; i < 150; i++)
      convertir(10'($urandom_range(0, 1023)), $urandom_range(0, 3));

    // Back-pressure with noisy inputs: no second accept may sneak in.
    @(negedge clk);
    datoEntrada = 10'd200;
    entrada_valida = 1'b1;
    @(posedge clk);
    #1;
    entrada_valida = 1'b0;
    lat = 0;
    while (!salida_valida && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latencia", lat, 12);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      datoEntrada = 10'($urandom_range(0, 1023));
      entrada_valida = i[0];
      chk("bp_lista", {31'd0, entrada_lista}, 32'd0);
      chk("bp_valida", {31'd0, salida_valida}, 32'd1);
      chk("bp_dato", {24'd0, datoSalida}, 32'd80);
      chk("bp_img", {31'd0, en_imagen}, 32'd1);
    end
    @(negedge clk);
    entrada_valida = 1'b0;
    salida_lista = 1'b1;
    @(posedge clk);
    #1;
    salida_lista = 1'b0;
    chk("bp_handshake", {31'd0, salida_valida}, 32'd0);
    chk("bp_reposo", {31'd0, entrada_lista}, 32'd1);
    repeat (15) begin
      @(negedge clk);
      chk("bp_sin_segundo", {31'd0, salida_valida}, 32'd0);
    end

    // Reset in the middle of a division.
    @(negedge clk);
    datoEntrada = 10'd100;
    entrada_valida = 1'b1;
    @(posedge clk);
    #1;
    entrada_valida = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valida", {31'd0, salida_valida}, 32'd0);
    chk("abort_lista", {31'd0, entrada_lista}, 32'd1);
    chk("abort_dato", {24'd0, datoSalida}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      chk("abort_sin_resultado", {31'd0, salida_valida}, 32'd0);
    end
    convertir(10'd10, 0);
    chk("abort_dato10", {24'd0, datoSalida}, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
